// File: rtl/data_memory_if.sv
// Data-cache miss port: line request/ack bundle between the cache controller
// (master) and the backing line memory (slave). Signal suffixes are named from
// the memory's side of the link.
interface data_memory_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/data_memory.sv
// Line-granular data memory behind the data cache. Accepts one 256-bit line
// read or write, holds it for LATENCY cycles, then completes it with a
// one-cycle ack. Dropping enable while busy abandons the request.
//
// state | meaning
// IDLE  | waiting; enable at an edge accepts a request
// BUSY  | latency count running; enable low aborts
// ACK   | ack_o high for this one cycle; enable ignored
module data_memory #(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  data_memory_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [255:0]       wdata_q;
  logic               ack_q;
  logic [255:0]       rdata_q;
  logic [255:0]       mem_q [DEPTH_LINES];

  logic accept;
  logic complete;

  assign accept   = (state_q == IDLE) && bus.enable_i;
  assign complete = (state_q == BUSY) && bus.enable_i && (cnt_q == '0);

  // Offset bits and address bits above the line index are don't-care; lines alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};

  // Capture the request at acceptance; later bus changes are ignored.
  // Not reset: these are only consumed after a fresh acceptance.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= bus.addr_i[IDX_W+4:5];
      wr_q    <= bus.write_i;
      wdata_q <= bus.data_i;
    end
  end

  // Line array commits a write only on the edge that enters ACK, so an
  // aborted or reset request never touches memory. Contents are not reset.
  always_ff @(posedge clk_i) begin
    if (complete && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Request sequencing with registered ack and read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.enable_i) begin
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.enable_i) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
            if (!wr_q) begin
              rdata_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          // Always pass through IDLE so a held enable becomes a new request.
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed vector table, hand sequences for
// back-to-back, abort, reset and LATENCY=1, then randomized traffic checked
// against a line-array model with fixed request latency.
module tb_data_memory;
  localparam int LAT = 10;

  logic clk;
  logic rst_n;

  data_memory_if bus ();
  data_memory_if bus1 ();

  data_memory #(.LATENCY(LAT), .DEPTH_LINES(512)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  data_memory #(.LATENCY(1), .DEPTH_LINES(512)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference: sparse line array keyed by line index, plus last read value.
  logic [255:0] mem_m [int];
  logic [255:0] last_rd_m;
  bit           last_rd_known;

  typedef struct {
    logic         w;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp;
    bit           chk;
  } vec_t;

  function automatic int line_of(input logic [31:0] a);
    return int'(a[13:5]);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void chk_int(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  // One complete request on the LAT instance. Scrambles the bus after
  // acceptance to confirm captured values are used.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                        input string nm, output logic [255:0] got);
    int n;
    bit seen;
    int ln;
    ln = line_of(a);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = w;
    bus.addr_i   = a;
    bus.data_i   = d;
    @(posedge clk);
    #1;
    chk({nm, " ack_after_accept"}, 256'(bus.ack_o), 256'(0));
    @(negedge clk);
    bus.write_i = ~w;
    bus.addr_i  = $urandom;
    bus.data_i  = rnd256();
    seen = 1'b0;
    n = 0;
    got = '0;
    while (!seen && n < LAT + 4) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ack_o === 1'b1) seen = 1'b1;
    end
    chk_int({nm, " latency"}, seen ? n : -1, LAT);
    if (seen) begin
      got = bus.data_o;
      if (w) begin
        if (last_rd_known) chk({nm, " data_o_hold"}, got, last_rd_m);
        mem_m[ln] = d;
      end else if (mem_m.exists(ln)) begin
        chk({nm, " rdata"}, got, mem_m[ln]);
        last_rd_m = mem_m[ln];
        last_rd_known = 1'b1;
      end else begin
        last_rd_known = 1'b0;
      end
    end
    @(negedge clk);
    bus.enable_i = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " ack_width"}, 256'(bus.ack_o), 256'(0));
  endtask

  // Accept a request, keep enable high for k-1 more edges, drop it at edge k.
  task automatic do_abort(input logic w, input logic [31:0] a, input logic [255:0] d,
                          input int k, input string nm);
    int acks;
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = w;
    bus.addr_i   = a;
    bus.data_i   = d;
    @(posedge clk);
    acks = 0;
    for (int i = 1; i < k; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o === 1'b1) acks++;
    end
    @(negedge clk);
    bus.enable_i = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o !== 1'b0) acks++;
    end
    chk_int({nm, " abort_no_ack"}, acks, 0);
  endtask

  vec_t tbl [10];
  logic [255:0] got;
  logic [255:0] pat;
  logic [255:0] p_old;
  int n;
  bit seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable_i  = 1'b0;
    bus.write_i   = 1'b0;
    bus.addr_i    = '0;
    bus.data_i    = '0;
    bus1.enable_i = 1'b0;
    bus1.write_i  = 1'b0;
    bus1.addr_i   = '0;
    bus1.data_i   = '0;
    last_rd_m     = '0;
    last_rd_known = 1'b1;
    rst_n         = 1'b0;

    // Reset held with a request pending: nothing accepted, outputs zero.
    bus.enable_i = 1'b1;
    bus.addr_i   = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset ack", 256'(bus.ack_o), 256'(0));
      chk("reset data_o", bus.data_o, 256'(0));
    end
    bus.enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0040, '0, "first_read", got);

    // Directed vector table.
    tbl[0] = '{1'b1, 32'h0000_1000, 256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF, '0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_101C, '0, 256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF, 1'b1};
    tbl[2] = '{1'b1, 32'h0000_0020, {32{8'h11}}, '0, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_4020, '0, {32{8'h11}}, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_3FE0, {16{16'hC3A5}}, '0, 1'b0};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF, '0, {16{16'hC3A5}}, 1'b1};
    tbl[6] = '{1'b1, 32'h8000_0000, {8{32'hDEAD_BEEF}}, '0, 1'b0};
    tbl[7] = '{1'b0, 32'h0000_001F, '0, {8{32'hDEAD_BEEF}}, 1'b1};
    tbl[8] = '{1'b1, 32'h0000_1000, {4{64'hFEDC_BA98_7654_3210}}, '0, 1'b0};
    tbl[9] = '{1'b0, 32'h0000_1000, '0, {4{64'hFEDC_BA98_7654_3210}}, 1'b1};
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].w, tbl[i].addr, tbl[i].wdata, $sformatf("tbl%0d", i), got);
      if (tbl[i].chk) chk($sformatf("tbl%0d expected", i), got, tbl[i].exp);
    end

    // Back-to-back: writeback of 0x400 then refill of 0x800 with enable held.
    do_req(1'b1, 32'h0000_0800, {32{8'h55}}, "b2b preload", got);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0400;
    bus.data_i   = {32{8'hAA}};
    @(posedge clk);
    seen = 1'b0;
    n = 0;
    while (!seen && n < LAT + 4) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ack_o === 1'b1) seen = 1'b1;
    end
    chk_int("b2b first latency", seen ? n : -1, LAT);
    mem_m[line_of(32'h0000_0400)] = {32{8'hAA}};
    @(negedge clk);
    bus.write_i = 1'b0;
    bus.addr_i  = 32'h0000_0800;
    @(posedge clk);
    #1;
    chk("b2b ack_fall", 256'(bus.ack_o), 256'(0));
    seen = 1'b0;
    n = 0;
    while (!seen && n < LAT + 4) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ack_o === 1'b1) seen = 1'b1;
    end
    chk_int("b2b second ack edges after fall", seen ? n : -1, LAT + 1);
    chk("b2b refill data", bus.data_o, {32{8'h55}});
    last_rd_m = {32{8'h55}};
    last_rd_known = 1'b1;
    @(negedge clk);
    bus.enable_i = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b second ack_width", 256'(bus.ack_o), 256'(0));
    do_req(1'b0, 32'h0000_0400, '0, "b2b writeback check", got);
    chk("b2b line 0x400", got, {32{8'hAA}});

    // Abort: write dropped at cycle 4 leaves the line untouched.
    p_old = rnd256();
    do_req(1'b1, 32'h0000_0200, p_old, "abort preload", got);
    do_abort(1'b1, 32'h0000_0200, {256{1'b1}}, 4, "abort c4");
    do_abort(1'b1, 32'h0000_0200, {256{1'b1}}, LAT, "abort last");
    do_req(1'b0, 32'h0000_0200, '0, "abort readback", got);
    chk("abort old contents", got, p_old);

    // Reset in the middle of a write.
    p_old = rnd256();
    do_req(1'b1, 32'h0000_0600, p_old, "rst preload", got);
    do_req(1'b0, 32'h0000_0600, '0, "rst prime data_o", got);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0600;
    bus.data_i   = rnd256();
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst mid ack", 256'(bus.ack_o), 256'(0));
    chk("rst mid data_o", bus.data_o, 256'(0));
    last_rd_m = '0;
    last_rd_known = 1'b1;
    @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0600, '0, "rst readback", got);
    chk("rst old contents", got, p_old);

    // LATENCY=1 instance: ack one edge after accept.
    pat = rnd256();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      bus1.enable_i = 1'b1;
      bus1.write_i  = (r == 0);
      bus1.addr_i   = 32'h0000_0EE0;
      bus1.data_i   = pat;
      @(posedge clk);
      #1;
      chk($sformatf("lat1 r%0d ack_at_accept", r), 256'(bus1.ack_o), 256'(0));
      @(posedge clk);
      #1;
      chk($sformatf("lat1 r%0d ack", r), 256'(bus1.ack_o), 256'(1));
      if (r == 1) chk("lat1 rdata", bus1.data_o, pat);
      @(negedge clk);
      bus1.enable_i = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("lat1 r%0d ack_width", r), 256'(bus1.ack_o), 256'(0));
    end

    // Randomized traffic over a small pool of lines with random alias/offset bits.
    for (int j = 0; j < 16; j++) begin
      logic [31:0] a;
      a = $urandom;
      a[13:5] = 9'(j * 29 + 3);
      do_req(1'b1, a, rnd256(), $sformatf("rnd preload%0d", j), got);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int op;
      a = $urandom;
      a[13:5] = 9'($urandom_range(0, 15) * 29 + 3);
      op = int'($urandom_range(0, 9));
      if (op < 2)
        do_abort(op[0], a, rnd256(), int'($urandom_range(1, LAT)), $sformatf("rnd%0d", i));
      else
        do_req(op < 5, a, rnd256(), $sformatf("rnd%0d", i), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Line-granular data memory: the responder end of the data-cache miss interface. Accepts 256-bit line read and write requests from the data-cache controller, holds them for a fixed latency, then completes each with a one-cycle acknowledge. It sits between the data-cache controller's memory port and the top-level testbench/CPU wrapper and models main memory behind the cache.

## Interface
- LATENCY, 10: cycles from request acceptance to ack; legal range 1..255.
- DEPTH_LINES, 512: number of 256-bit lines; power of two.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset; one clock; reset is asynchronous and active-low.
- enable_i  input  1  request valid; held high by the initiator until ack.
- write_i  input  1  1 = line write, 0 = line read; sampled at acceptance.
- addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[log2(DEPTH_LINES)+4:5]; higher bits ignored, so addresses alias.
- data_i  input  256  write line; sampled at acceptance.
- ack_o  output  1  completion pulse, exactly one cycle per completed request.
- data_o  output  256  read line; valid while ack_o is high for a read.

## Operation
- States: IDLE, BUSY, ACK.
- IDLE: if enable_i=1 at the edge, accept: latch index, write_i, data_i; load counter with LATENCY-1; go BUSY.
- BUSY: if enable_i=0 at an edge -> abort: IDLE, no ack, no array write. Otherwise, counter=0 -> ACK; else decrement.
- Entering ACK (same edge): ack_o<=1; write: array[index]<=latched data; read: data_o<=array[index].
- ACK: unconditionally -> IDLE, ack_o<=0. enable_i is ignored during ACK, even if still high.
- IDLE always lasts at least one cycle after ACK. A request held continuously across an ack is treated as a new request, accepted at the next edge in IDLE. This supports the controller's back-to-back writeback-then-refill: enable stays high, write drops.
- Changes to addr_i, write_i or data_i after acceptance are ignored.
- data_o holds its last read value until the next read completes. Writes do not change data_o.
- Array contents are not reset. Only state, counter, ack_o and data_o reset.
- Counter width is the minimum needed to hold LATENCY-1. LATENCY=1 goes BUSY -> ACK on the first BUSY edge.

## Timing
- Reset (async assert, any state, including mid-request): state=IDLE, counter=0, ack_o=0, data_o=0. An in-flight write is dropped and the array is unchanged.
- Deassertion of rst_i is followed by normal operation on the next rising edge.
- Accept at edge E0: ack_o rises at edge E0+LATENCY and falls at E0+LATENCY+1.
- Write becomes visible to reads accepted at or after E0+LATENCY+1.
- Minimum spacing between acceptances is LATENCY+2 edges.
- Read after write to the same line, back-to-back, returns the written data.
- Abort is detected at the first edge where enable_i=0 in BUSY. The same edge that aborts cannot accept a new request; the earliest new acceptance is the next edge.

## Test plan
- Reset: hold rst_i=0 with enable_i=1 for 3 cycles -> ack_o=0, data_o=0, no acceptance. Release, then drive a read of 0x0000_0040 -> ack_o high exactly 10 cycles after the accept edge, for 1 cycle.
- Write/read: write 256'h0123…CDEF to 0x0000_1000. Drop enable on ack, then read 0x0000_101C -> data_o=256'h0123…CDEF during ack (offset bits ignored). Each ack is one cycle wide.
- Back-to-back (controller writeback then refill): keep enable_i high across the ack; write 0xAA.. to line 0x400, then read 0x800 (preloaded 0x55..) -> second accept one edge after ack falls; second ack 10 edges later with data_o=0x55..; line 0x400 holds 0xAA...
- Abort: accept write of 0xFF.. to 0x200, drop enable_i at cycle 4 -> no ack ever. A later read of 0x200 returns the previous contents.
- Aliasing: with DEPTH_LINES=512, write 0x11.. to 0x0000_0020, then read 0x0000_4020 -> data_o=0x11...
- Reset mid-write: assert rst_i at cycle 5 of a write -> ack_o=0 immediately. After release, a read of that line returns the old data. LATENCY=1 variant: ack exactly 1 edge after accept.
